// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared RV32 opcodes, immediate-format select and fetch buffer entry
package fetch_unit_pkg;
  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_NONE = 3'b111
  } imm_sel_t;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    imm_sel_t    imm_sel;
  } fetch_entry_t;
  function automatic imm_sel_t imm_sel_of(input logic [6:0] op);
    return (op == OP_IMM || op == OP_LOAD || op == OP_JALR || op == OP_SYSTEM) ? IMM_I :
           op == OP_STORE ? IMM_S :
           op == OP_BRANCH ? IMM_B :
           (op == OP_LUI || op == OP_AUIPC) ? IMM_U :
           op == OP_JAL ? IMM_J : IMM_NONE;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decode handshakes of the fetch stage
interface fetch_unit_if;
  import fetch_unit_pkg::*;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  imm_sel_t    instr_imm_sel;
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc, instr_imm_sel,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc, instr_imm_sel,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush whose head is read straight from registers
module fetch_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  // Storage and pointers; reset clears entries so the head reads zero
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetch with buffered, pre-decoded delivery to decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0]   fetch_pc, rsp_pc, redir_pc;
  logic [CW-1:0] outstanding, discard, count;
  logic          req_fire, drop, push, pop;
  fetch_entry_t  head;
  assign redir_pc = {bus.redirect_pc[31:2], 2'b00};
  assign bus.imem_req_valid = rst_n && !bus.redirect_valid && (32'(outstanding) + 32'(count) < 32'(DEPTH));
  assign bus.imem_req_addr = fetch_pc;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign drop = discard != '0;
  assign push = bus.imem_rsp_valid && !drop && !bus.redirect_valid;
  assign pop = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;
  assign bus.instr_valid = rst_n && count != '0;
  assign bus.instr_out = head.instr;
  assign bus.instr_pc = head.pc;
  assign bus.instr_imm_sel = head.imm_sel;
  fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   ({bus.imem_rsp_data, rsp_pc, imm_sel_of(bus.imem_rsp_data[6:0])}),
    .dout  (head),
    .count (count)
  );
  // PCs and in-flight bookkeeping; stale responses are already part of outstanding,
  // so on redirect every response still in flight (minus one arriving now) becomes stale
  always_ff @(posedge clk)
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      fetch_pc    <= bus.redirect_valid ? redir_pc : req_fire ? fetch_pc + 32'd4 : fetch_pc;
      rsp_pc      <= bus.redirect_valid ? redir_pc : push ? rsp_pc + 32'd4 : rsp_pc;
      outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      discard     <= bus.redirect_valid ? outstanding - CW'(bus.imem_rsp_valid)
                                        : discard - CW'(bus.imem_rsp_valid && drop);
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios against an in-order instruction memory model
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  bit decode_mode = 1'b0;
  logic [31:0] aq[$];
  int          dq[$];
  logic [31:0] reqs[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_in[$];
  logic [2:0]  got_sel[$];
  int          got_cyc[$];
  logic [31:0] dtab [8] = '{32'h00C58063, 32'hFE112E23, 32'h000000EF, 32'h00B50533,
                            32'h00000013, 32'h12345037, 32'h00000017, 32'h00002003};

  fetch_unit_if bus();
  fetch_unit #(.RESET_PC(32'h100), .DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return decode_mode ? dtab[a[4:2]] : {a[26:2], 7'b0110011};
  endfunction

  task automatic clear_log();
    reqs.delete(); got_pc.delete(); got_in.delete(); got_sel.delete(); got_cyc.delete();
  endtask

  task automatic cycle();
    #1;
    if (!rst_n) begin
      aq.delete(); dq.delete();
    end else begin
      if (bus.imem_rsp_valid) begin
        void'(aq.pop_front()); void'(dq.pop_front());
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        aq.push_back(bus.imem_req_addr); dq.push_back(cyc + lat); reqs.push_back(bus.imem_req_addr);
      end
      if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
        got_pc.push_back(bus.instr_pc); got_in.push_back(bus.instr_out);
        got_sel.push_back(bus.instr_imm_sel); got_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n && aq.size() > 0 && dq[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = mem_word(aq[0]);
    end else begin
      bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.instr_ready = 1'b1; bus.imem_req_ready = 1'b1;
    repeat (2) cycle();
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    int base;
    do_reset();
    repeat (5) cycle();
    rst_n = 1'b0;
    cycle();
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b exp=0", bus.imem_req_valid); end
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%0b exp=0", bus.instr_valid); end
    checks++; if (bus.imem_req_addr !== 32'h100) begin failures++; $display("FAIL reset_req_addr got=%h exp=00000100", bus.imem_req_addr); end
    checks++; if (bus.instr_out !== 32'h0) begin failures++; $display("FAIL reset_instr_out got=%h exp=0", bus.instr_out); end
    checks++; if (bus.instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc got=%h exp=0", bus.instr_pc); end
    checks++; if (bus.instr_imm_sel !== IMM_I) begin failures++; $display("FAIL reset_imm_sel got=%0d exp=0", bus.instr_imm_sel); end
    cycle();
    rst_n = 1'b1;
    clear_log();
    base = cyc;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid got=%0b exp=1", bus.imem_req_valid); end
    repeat (6) cycle();
    checks++;
    if (reqs.size() < 3) begin failures++; $display("FAIL reset_req_count got=%0d exp>=3", reqs.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (reqs[i] !== 32'h100 + 32'(4 * i)) begin failures++; $display("FAIL reset_req_addr%0d got=%h exp=%h", i, reqs[i], 32'h100 + 32'(4 * i)); end
    end
    checks++;
    if (got_pc.size() < 2) begin failures++; $display("FAIL reset_deliv_count got=%0d exp>=2", got_pc.size()); end
    else begin
      checks++; if (got_pc[0] !== 32'h100) begin failures++; $display("FAIL reset_pc0 got=%h exp=00000100", got_pc[0]); end
      checks++; if (got_pc[1] !== 32'h104) begin failures++; $display("FAIL reset_pc1 got=%h exp=00000104", got_pc[1]); end
      checks++; if (got_cyc[0] !== base + 2) begin failures++; $display("FAIL reset_latency got=%0d exp=%0d", got_cyc[0] - base, 2); end
      checks++; if (got_cyc[1] !== base + 3) begin failures++; $display("FAIL reset_rate got=%0d exp=%0d", got_cyc[1] - base, 3); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.instr_ready = 1'b0;
    repeat (6) cycle();
    checks++; if (reqs.size() !== 2) begin failures++; $display("FAIL bp_req_count got=%0d exp=2", reqs.size()); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got=%0b exp=0", bus.imem_req_valid); end
    checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL bp_instr_valid got=%0b exp=1", bus.instr_valid); end
    repeat (3) cycle();
    checks++; if (bus.instr_pc !== 32'h100) begin failures++; $display("FAIL bp_hold_pc got=%h exp=00000100", bus.instr_pc); end
    checks++; if (bus.instr_out !== mem_word(32'h100)) begin failures++; $display("FAIL bp_hold_instr got=%h exp=%h", bus.instr_out, mem_word(32'h100)); end
    bus.instr_ready = 1'b1;
    repeat (14) cycle();
    checks++;
    if (got_pc.size() < 4) begin failures++; $display("FAIL bp_drain_count got=%0d exp>=4", got_pc.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (got_pc[i] !== 32'h100 + 32'(4 * i)) begin failures++; $display("FAIL bp_drain_pc%0d got=%h exp=%h", i, got_pc[i], 32'h100 + 32'(4 * i)); end
      checks++; if (got_in[i] !== mem_word(32'h100 + 32'(4 * i))) begin failures++; $display("FAIL bp_drain_instr%0d got=%h exp=%h", i, got_in[i], mem_word(32'h100 + 32'(4 * i))); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 3;
    repeat (2) cycle();
    checks++; if (reqs.size() !== 2) begin failures++; $display("FAIL redir_outstanding got=%0d exp=2", reqs.size()); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h2003;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_req_suppressed got=%0b exp=0", bus.imem_req_valid); end
    cycle();
    bus.redirect_valid = 1'b0;
    clear_log();
    repeat (14) cycle();
    checks++;
    if (reqs.size() < 1 || got_pc.size() < 2) begin failures++; $display("FAIL redir_progress reqs=%0d deliv=%0d exp>=1,>=2", reqs.size(), got_pc.size()); end
    else begin
      checks++; if (reqs[0] !== 32'h2000) begin failures++; $display("FAIL redir_req_addr got=%h exp=00002000", reqs[0]); end
      checks++; if (got_pc[0] !== 32'h2000) begin failures++; $display("FAIL redir_pc0 got=%h exp=00002000", got_pc[0]); end
      checks++; if (got_pc[1] !== 32'h2004) begin failures++; $display("FAIL redir_pc1 got=%h exp=00002004", got_pc[1]); end
      checks++; if (got_in[0] !== mem_word(32'h2000)) begin failures++; $display("FAIL redir_instr0 got=%h exp=%h", got_in[0], mem_word(32'h2000)); end
    end
    lat = 1;
  endtask

  task automatic test_redirect_collision();
    do_reset();
    repeat (2) cycle();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h3000;
    #1;
    checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL coll_pre_valid got=%0b exp=1", bus.instr_valid); end
    checks++; if (bus.instr_pc !== 32'h100) begin failures++; $display("FAIL coll_pre_pc got=%h exp=00000100", bus.instr_pc); end
    cycle();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL coll_flushed got=%0b exp=0", bus.instr_valid); end
    clear_log();
    repeat (8) cycle();
    checks++;
    if (reqs.size() < 1 || got_pc.size() < 2) begin failures++; $display("FAIL coll_progress reqs=%0d deliv=%0d exp>=1,>=2", reqs.size(), got_pc.size()); end
    else begin
      checks++; if (reqs[0] !== 32'h3000) begin failures++; $display("FAIL coll_req_addr got=%h exp=00003000", reqs[0]); end
      checks++; if (got_pc[0] !== 32'h3000) begin failures++; $display("FAIL coll_pc0 got=%h exp=00003000", got_pc[0]); end
      checks++; if (got_pc[1] !== 32'h3004) begin failures++; $display("FAIL coll_pc1 got=%h exp=00003004", got_pc[1]); end
    end
  endtask

  task automatic test_decode();
    logic [2:0] exp_sel [8] = '{3'b010, 3'b001, 3'b100, 3'b111, 3'b000, 3'b011, 3'b011, 3'b000};
    decode_mode = 1'b1;
    do_reset();
    repeat (26) cycle();
    checks++;
    if (got_sel.size() < 8) begin failures++; $display("FAIL dec_count got=%0d exp>=8", got_sel.size()); end
    else for (int i = 0; i < 8; i++) begin
      checks++; if (got_sel[i] !== exp_sel[i]) begin failures++; $display("FAIL dec_sel%0d instr=%h got=%b exp=%b", i, got_in[i], got_sel[i], exp_sel[i]); end
      checks++; if (got_in[i] !== dtab[i]) begin failures++; $display("FAIL dec_instr%0d got=%h exp=%h", i, got_in[i], dtab[i]); end
    end
    decode_mode = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    cycle();
    bus.redirect_valid = 1'b0;
    clear_log();
    repeat (8) cycle();
    checks++;
    if (reqs.size() < 2 || got_pc.size() < 2) begin failures++; $display("FAIL wrap_progress reqs=%0d deliv=%0d exp>=2,>=2", reqs.size(), got_pc.size()); end
    else begin
      checks++; if (reqs[0] !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req0 got=%h exp=fffffffc", reqs[0]); end
      checks++; if (reqs[1] !== 32'h0) begin failures++; $display("FAIL wrap_req1 got=%h exp=00000000", reqs[1]); end
      checks++; if (got_pc[0] !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc0 got=%h exp=fffffffc", got_pc[0]); end
      checks++; if (got_pc[1] !== 32'h0) begin failures++; $display("FAIL wrap_pc1 got=%h exp=00000000", got_pc[1]); end
    end
  endtask

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b1;
    test_reset();
    test_backpressure();
    test_redirect();
    test_redirect_collision();
    test_decode();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
